// File: rtl/dmem_b_port.sv
// rtl/dmem_b_port.sv - data-memory responder on the addr_b port with posted write and loader
module dmem_b_port #(
   parameter int DEPTH_LOG2 = 10
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] addr_b,
   input  logic [3:0]  addr_b_start,
   input  logic [31:0] addr_b_write,
   output logic [31:0] addr_b_read,
   input  logic        ld_valid,
   output logic        ld_ready,
   input  logic [31:0] ld_addr,
   input  logic [31:0] ld_data,
   output logic        mem_ready,
   output logic        err_oob,
   output logic        err_busy,
   input  logic        err_clr
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   typedef enum logic {
      ST_CLEAR,
      ST_READY
   } state_t;

   state_t                state;
   logic [DEPTH_LOG2-1:0] clr_cnt;

   // one-entry posted-write register; always drains on the cycle after capture
   logic                  post_valid;
   logic [DEPTH_LOG2-1:0] post_idx;
   logic [31:0]           post_data;
   logic [3:0]            post_mask;

   logic [31:0]           mem [DEPTH];

   logic [DEPTH_LOG2-1:0] b_idx;
   logic [DEPTH_LOG2-1:0] ld_idx;
   logic                  b_oob;
   logic                  ld_oob;
   logic                  b_wr;
   logic                  ld_fire;
   logic                  busy_evt;
   logic                  oob_evt;

   logic                  we;
   logic [DEPTH_LOG2-1:0] w_idx;
   logic [31:0]           w_data;
   logic [3:0]            w_mask;
   logic [31:0]           rd_word;

   // byte-offset bits are ignored; kept here only so every input bit is consumed
   logic                  unused_lo;

   assign b_idx     = addr_b[DEPTH_LOG2+1:2];
   assign ld_idx    = ld_addr[DEPTH_LOG2+1:2];
   assign b_oob     = |addr_b[31:DEPTH_LOG2+2];
   assign ld_oob    = |ld_addr[31:DEPTH_LOG2+2];
   assign b_wr      = (addr_b_start != 4'b0000);
   assign unused_lo = ^{addr_b[1:0], ld_addr[1:0]};

   // loader only gets the write port when no store is arriving or draining
   assign ld_ready  = (state == ST_READY) && !b_wr && !post_valid;
   assign ld_fire   = ld_valid && ld_ready;

   assign busy_evt  = (state == ST_CLEAR) && (b_wr || ld_valid);
   assign oob_evt   = (state == ST_READY) && (b_oob || (ld_fire && ld_oob));

   // single RAM write port: clear sequencer, then posted drain, then loader
   always_comb begin
      we     = 1'b0;
      w_idx  = '0;
      w_data = 32'h0;
      w_mask = 4'b0000;
      if (state == ST_CLEAR) begin
         we     = 1'b1;
         w_idx  = clr_cnt;
         w_mask = 4'b1111;
      end else if (post_valid) begin
         we     = 1'b1;
         w_idx  = post_idx;
         w_data = post_data;
         w_mask = post_mask;
      end else if (ld_fire && !ld_oob) begin
         we     = 1'b1;
         w_idx  = ld_idx;
         w_data = ld_data;
         w_mask = 4'b1111;
      end
   end

   // RAM byte-lane write; contents are not reset, the clear sequence zeroes them
   always_ff @(posedge clk) begin
      for (int k = 0; k < 4; k++) begin
         if (we && w_mask[k]) begin
            mem[w_idx][8*k +: 8] <= w_data[8*k +: 8];
         end
      end
   end

   // asynchronous read with byte-wise forwarding from the older posted entry
   always_comb begin
      rd_word = mem[b_idx];
      for (int k = 0; k < 4; k++) begin
         if (post_valid && (post_idx == b_idx) && post_mask[k]) begin
            rd_word[8*k +: 8] = post_data[8*k +: 8];
         end
      end
      addr_b_read = ((state == ST_READY) && !b_oob) ? rd_word : 32'h0;
   end

   // control FSM, posted-write capture and sticky error flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_CLEAR;
         clr_cnt    <= '0;
         mem_ready  <= 1'b0;
         post_valid <= 1'b0;
         post_idx   <= '0;
         post_data  <= 32'h0;
         post_mask  <= 4'b0000;
         err_oob    <= 1'b0;
         err_busy   <= 1'b0;
      end else begin
         case (state)
            ST_CLEAR: begin
               clr_cnt    <= clr_cnt + 1'b1;
               post_valid <= 1'b0;
               if (&clr_cnt) begin
                  state     <= ST_READY;
                  mem_ready <= 1'b1;
               end
            end
            ST_READY: begin
               post_valid <= b_wr && !b_oob;
               if (b_wr && !b_oob) begin
                  post_idx  <= b_idx;
                  post_data <= addr_b_write;
                  post_mask <= addr_b_start;
               end
            end
            default: begin
               state     <= ST_CLEAR;
               clr_cnt   <= '0;
               mem_ready <= 1'b0;
            end
         endcase

         if (oob_evt) begin
            err_oob <= 1'b1;
         end else if (err_clr) begin
            err_oob <= 1'b0;
         end

         if (busy_evt) begin
            err_busy <= 1'b1;
         end else if (err_clr) begin
            err_busy <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_dmem_b_port.sv
// tb/tb_dmem_b_port.sv - self-checking bench for dmem_b_port with a visible-memory model
module tb_dmem_b_port;

   localparam int DL    = 4;
   localparam int DEPTH = 16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] addr_b;
   logic [3:0]  addr_b_start;
   logic [31:0] addr_b_write;
   logic [31:0] addr_b_read;
   logic        ld_valid;
   logic        ld_ready;
   logic [31:0] ld_addr;
   logic [31:0] ld_data;
   logic        mem_ready;
   logic        err_oob;
   logic        err_busy;
   logic        err_clr;

   int total = 0;
   int bad   = 0;

   // what a reader should see: a store becomes visible the cycle after it is presented
   logic [31:0] model [DEPTH];

   always #5 clk = ~clk;

   dmem_b_port #(.DEPTH_LOG2(DL)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .addr_b       (addr_b),
      .addr_b_start (addr_b_start),
      .addr_b_write (addr_b_write),
      .addr_b_read  (addr_b_read),
      .ld_valid     (ld_valid),
      .ld_ready     (ld_ready),
      .ld_addr      (ld_addr),
      .ld_data      (ld_data),
      .mem_ready    (mem_ready),
      .err_oob      (err_oob),
      .err_busy     (err_busy),
      .err_clr      (err_clr)
   );

   function automatic logic [31:0] model_read(input logic [31:0] a);
      if (a[31:DL+2] != 0) return 32'h0;
      return model[a[DL+1:2]];
   endfunction

   function automatic void model_store(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
      if (a[31:DL+2] != 0) return;
      for (int k = 0; k < 4; k++)
         if (m[k]) model[a[DL+1:2]][8*k +: 8] = d[8*k +: 8];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      addr_b       = 32'h0;
      addr_b_start = 4'b0000;
      addr_b_write = 32'h0;
      ld_valid     = 1'b0;
      ld_addr      = 32'h0;
      ld_data      = 32'h0;
      err_clr      = 1'b0;
   endtask

   // present one store for a cycle; returns the read value seen during that cycle
   task automatic store_cycle(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d,
                              output logic [31:0] pre_rd);
      addr_b       = a;
      addr_b_start = m;
      addr_b_write = d;
      #1;
      pre_rd = addr_b_read;
      tick();
      model_store(a, m, d);
      addr_b_start = 4'b0000;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle_inputs();
      repeat (3) tick();
      total++; if (mem_ready !== 1'b0) begin bad++; $display("FAIL reset_mem_ready got=%b exp=0", mem_ready); end
      total++; if (ld_ready !== 1'b0) begin bad++; $display("FAIL reset_ld_ready got=%b exp=0", ld_ready); end
      total++; if (err_oob !== 1'b0) begin bad++; $display("FAIL reset_err_oob got=%b exp=0", err_oob); end
      total++; if (err_busy !== 1'b0) begin bad++; $display("FAIL reset_err_busy got=%b exp=0", err_busy); end
      total++; if (addr_b_read !== 32'h0) begin bad++; $display("FAIL reset_read got=%h exp=0", addr_b_read); end
      rst_n = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         addr_b = 32'($urandom_range(0, DEPTH - 1)) << 2;
         #1;
         total++; if (mem_ready !== 1'b0) begin bad++; $display("FAIL clear_mem_ready cyc=%0d got=%b exp=0", i, mem_ready); end
         total++; if (addr_b_read !== 32'h0) begin bad++; $display("FAIL clear_read cyc=%0d got=%h exp=0", i, addr_b_read); end
         tick();
      end
      addr_b = 32'h0;
      total++; if (mem_ready !== 1'b1) begin bad++; $display("FAIL clear_done_mem_ready got=%b exp=1", mem_ready); end
      for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
      for (int i = 0; i < DEPTH; i++) begin
         addr_b = 32'(i * 4);
         #1;
         total++; if (addr_b_read !== 32'h0) begin bad++; $display("FAIL cleared_word idx=%0d got=%h exp=0", i, addr_b_read); end
      end
   endtask

   task automatic test_write_forward();
      logic [31:0] pre;
      store_cycle(32'h8, 4'b1111, 32'hDEADBEEF, pre);
      total++; if (pre !== 32'h0) begin bad++; $display("FAIL wr_same_cycle_read got=%h exp=0", pre); end
      #1;
      total++; if (addr_b_read !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_forward got=%h exp=deadbeef", addr_b_read); end
      tick();
      tick();
      total++; if (addr_b_read !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_from_ram got=%h exp=deadbeef", addr_b_read); end
   endtask

   task automatic test_byte_lanes();
      logic [31:0] pre;
      store_cycle(32'h4, 4'b1111, 32'h11223344, pre);
      tick();
      store_cycle(32'h4, 4'b0001, 32'h000000AA, pre);
      total++; if (pre !== 32'h11223344) begin bad++; $display("FAIL lane_pre got=%h exp=11223344", pre); end
      #1;
      total++; if (addr_b_read !== 32'h112233AA) begin bad++; $display("FAIL lane0 got=%h exp=112233aa", addr_b_read); end
      store_cycle(32'h4, 4'b1000, 32'hBB000000, pre);
      total++; if (pre !== 32'h112233AA) begin bad++; $display("FAIL lane3_pre got=%h exp=112233aa", pre); end
      #1;
      total++; if (addr_b_read !== 32'hBB2233AA) begin bad++; $display("FAIL lane3 got=%h exp=bb2233aa", addr_b_read); end
      tick();
      total++; if (addr_b_read !== model_read(32'h4)) begin bad++; $display("FAIL lane_model got=%h exp=%h", addr_b_read, model_read(32'h4)); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] pre;
      store_cycle(32'h0, 4'b1111, 32'h1, pre);
      store_cycle(32'h4, 4'b1111, 32'h2, pre);
      total++; if (pre !== 32'hBB2233AA) begin bad++; $display("FAIL b2b_pre got=%h exp=bb2233aa", pre); end
      addr_b = 32'h0;
      #1;
      total++; if (addr_b_read !== 32'h1) begin bad++; $display("FAIL b2b_word0 got=%h exp=1", addr_b_read); end
      tick();
      tick();
      total++; if (addr_b_read !== 32'h1) begin bad++; $display("FAIL b2b_word0_late got=%h exp=1", addr_b_read); end
      addr_b = 32'h4;
      #1;
      total++; if (addr_b_read !== 32'h2) begin bad++; $display("FAIL b2b_word1 got=%h exp=2", addr_b_read); end
   endtask

   task automatic test_loader();
      addr_b       = 32'h10;
      addr_b_start = 4'b1111;
      addr_b_write = 32'h55;
      ld_valid     = 1'b1;
      ld_addr      = 32'hC;
      ld_data      = 32'hCAFEF00D;
      #1;
      total++; if (ld_ready !== 1'b0) begin bad++; $display("FAIL ld_ready_store got=%b exp=0", ld_ready); end
      tick();
      model_store(32'h10, 4'b1111, 32'h55);
      addr_b_start = 4'b0000;
      #1;
      total++; if (ld_ready !== 1'b0) begin bad++; $display("FAIL ld_ready_posted got=%b exp=0", ld_ready); end
      tick();
      total++; if (ld_ready !== 1'b1) begin bad++; $display("FAIL ld_ready_free got=%b exp=1", ld_ready); end
      tick();
      model[3] = 32'hCAFEF00D;
      ld_valid = 1'b0;
      addr_b   = 32'hC;
      #1;
      total++; if (addr_b_read !== 32'hCAFEF00D) begin bad++; $display("FAIL ld_word got=%h exp=cafef00d", addr_b_read); end
      addr_b = 32'h10;
      #1;
      total++; if (addr_b_read !== 32'h55) begin bad++; $display("FAIL ld_store_word got=%h exp=55", addr_b_read); end
   endtask

   task automatic test_random();
      logic        prev_store;
      logic [3:0]  m;
      logic [31:0] a;
      logic        exp_ldr;
      logic [31:0] exp_rd;
      idle_inputs();
      tick();
      prev_store = 1'b0;
      for (int n = 0; n < 300; n++) begin
         m = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
         a = 32'($urandom_range(0, DEPTH - 1)) << 2;
         addr_b       = a;
         addr_b_start = m;
         addr_b_write = $urandom;
         ld_valid     = ($urandom_range(0, 1) != 0);
         ld_addr      = 32'($urandom_range(0, DEPTH - 1)) << 2;
         ld_data      = $urandom;
         #1;
         exp_rd  = model_read(a);
         exp_ldr = (m == 4'b0000) && !prev_store;
         total++; if (addr_b_read !== exp_rd) begin bad++; $display("FAIL rnd_read n=%0d addr=%h got=%h exp=%h", n, a, addr_b_read, exp_rd); end
         total++; if (ld_ready !== exp_ldr) begin bad++; $display("FAIL rnd_ld_ready n=%0d got=%b exp=%b", n, ld_ready, exp_ldr); end
         tick();
         if (m != 4'b0000) model_store(a, m, addr_b_write);
         else if (ld_valid && exp_ldr) model[ld_addr[DL+1:2]] = ld_data;
         prev_store = (m != 4'b0000);
      end
      idle_inputs();
      tick();
      for (int i = 0; i < DEPTH; i++) begin
         addr_b = 32'(i * 4);
         #1;
         total++; if (addr_b_read !== model[i]) begin bad++; $display("FAIL rnd_final idx=%0d got=%h exp=%h", i, addr_b_read, model[i]); end
      end
      total++; if (err_oob !== 1'b0) begin bad++; $display("FAIL rnd_err_oob got=%b exp=0", err_oob); end
   endtask

   task automatic test_errors();
      logic [31:0] pre;
      logic [31:0] w0;
      w0 = model[0];
      store_cycle(32'h100, 4'b1111, 32'h12345678, pre);
      total++; if (pre !== 32'h0) begin bad++; $display("FAIL oob_read got=%h exp=0", pre); end
      total++; if (err_oob !== 1'b1) begin bad++; $display("FAIL oob_flag got=%b exp=1", err_oob); end
      addr_b = 32'h0;
      tick();
      total++; if (addr_b_read !== w0) begin bad++; $display("FAIL oob_no_change got=%h exp=%h", addr_b_read, w0); end
      addr_b  = 32'h100;
      err_clr = 1'b1;
      tick();
      total++; if (err_oob !== 1'b1) begin bad++; $display("FAIL oob_set_wins got=%b exp=1", err_oob); end
      addr_b = 32'h0;
      tick();
      err_clr = 1'b0;
      total++; if (err_oob !== 1'b0) begin bad++; $display("FAIL oob_clear got=%b exp=0", err_oob); end
      ld_valid = 1'b1;
      ld_addr  = 32'h200;
      ld_data  = 32'hFFFFFFFF;
      #1;
      total++; if (ld_ready !== 1'b1) begin bad++; $display("FAIL ld_oob_ack got=%b exp=1", ld_ready); end
      tick();
      ld_valid = 1'b0;
      total++; if (err_oob !== 1'b1) begin bad++; $display("FAIL ld_oob_flag got=%b exp=1", err_oob); end
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         addr_b = 32'(i * 4);
         #1;
         total++; if (addr_b_read !== model[i]) begin bad++; $display("FAIL err_mem idx=%0d got=%h exp=%h", i, addr_b_read, model[i]); end
      end
   endtask

   task automatic test_reset_midrun();
      int cnt;
      addr_b = 32'h0;
      #2;
      rst_n = 1'b0;
      #1;
      total++; if (mem_ready !== 1'b0) begin bad++; $display("FAIL mid_rst_mem_ready got=%b exp=0", mem_ready); end
      total++; if (addr_b_read !== 32'h0) begin bad++; $display("FAIL mid_rst_read got=%h exp=0", addr_b_read); end
      tick();
      rst_n        = 1'b1;
      addr_b_start = 4'b1111;
      addr_b_write = 32'hFFFFFFFF;
      tick();
      addr_b_start = 4'b0000;
      total++; if (err_busy !== 1'b1) begin bad++; $display("FAIL busy_flag got=%b exp=1", err_busy); end
      cnt = 0;
      while (!mem_ready && cnt < 40) begin
         tick();
         cnt++;
      end
      total++; if (cnt !== DEPTH - 1) begin bad++; $display("FAIL mid_reclear_cycles got=%0d exp=%0d", cnt, DEPTH - 1); end
      for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
      for (int i = 0; i < DEPTH; i++) begin
         addr_b = 32'(i * 4);
         #1;
         total++; if (addr_b_read !== model[i]) begin bad++; $display("FAIL reclear_word idx=%0d got=%h exp=0", i, addr_b_read); end
      end
      addr_b  = 32'h0;
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      total++; if (err_busy !== 1'b0) begin bad++; $display("FAIL busy_clear got=%b exp=0", err_busy); end
      total++; if (err_oob !== 1'b0) begin bad++; $display("FAIL oob_after_clear got=%b exp=0", err_oob); end
   endtask

   initial begin
      test_reset();
      test_write_forward();
      test_byte_lanes();
      test_back_to_back();
      test_loader();
      test_random();
      test_errors();
      test_reset_midrun();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dmem_b_port.md
Name: dmem_b_port

Overview:
- Data-memory responder on the addr_b access port.
- Serves the load/store unit, which drives addr_b, addr_b_start, addr_b_write and samples addr_b_read in the same cycle.
- Holds a word-organised RAM with byte-lane writes, a one-entry posted-write register with read forwarding, and a post-reset zero-clear sequencer.
- Also accepts a valid/ready program-loader port so memory can be preloaded before or between runs.

Parameters:
- DEPTH_LOG2, 10, log2 of the word count (DEPTH = 2**DEPTH_LOG2 32-bit words).

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- addr_b  in  32  byte address from the load/store unit; word index = addr_b[DEPTH_LOG2+1:2], bits [1:0] ignored
- addr_b_start  in  4  byte-lane write enables; bit k writes byte k (bits [8k+7:8k]); 4'b0000 = read only
- addr_b_write  in  32  store data, lane-aligned
- addr_b_read  out  32  combinational read data for addr_b
- ld_valid  in  1  loader word valid
- ld_ready  out  1  loader word accepted this cycle
- ld_addr  in  32  loader byte address, same indexing as addr_b
- ld_data  in  32  loader word, full 32-bit write
- mem_ready  out  1  clear sequence done, port live
- err_oob  out  1  sticky: out-of-range access seen
- err_busy  out  1  sticky: write attempted while not ready
- err_clr  in  1  synchronous clear of both sticky flags

Behaviour:
- Reset (rst_n=0, async): state=CLEAR, clr_cnt=0, posted register invalid, mem_ready=0, ld_ready=0, err_oob=0, err_busy=0. addr_b_read=0 while in CLEAR. RAM contents are not reset directly; the CLEAR state zeroes them.
- State CLEAR:
  - Each cycle writes 32'h0 to word clr_cnt, then clr_cnt += 1.
  - On the write of word DEPTH-1, goes to READY at the next edge. Total DEPTH cycles.
  - Any addr_b_start!=0 or ld_valid=1 in this state is dropped and sets err_busy. ld_ready stays 0.
- State READY:
  - mem_ready=1.
  - Out of range: an address is out of range when any bit of addr[31:DEPTH_LOG2+2] is nonzero.
  - Read: addr_b_read = RAM[idx]. If the posted register is valid with a matching idx, each byte whose mask bit is set comes from the posted data instead (byte-wise forwarding). An out-of-range read returns 0 and sets err_oob. Zero-cycle latency (combinational).
  - Write capture: if addr_b_start!=0 and in range, {idx, data, mask} is captured into the posted register at the edge. An out-of-range write is dropped and sets err_oob.
  - Drain: a valid posted register commits to RAM at the next edge, merging only the masked bytes.
  - A new capture in the same cycle as a drain is allowed: the old entry commits and the new one replaces it. No stall is ever needed, since the posted register always drains.
  - Read and write to the same address in one cycle: addr_b_read shows the pre-write value (RAM plus any older posted entry). The new data is visible from the next cycle via forwarding.
  - Loader:
    - ld_ready=1 only when state=READY, addr_b_start==0 and the posted register is invalid.
    - When ld_valid&&ld_ready, RAM[ld idx] = ld_data at the edge.
    - An out-of-range loader address is acknowledged, dropped, and sets err_oob.
  - Write-port priority: posted drain > loader. The CLEAR state is exclusive.
- Sticky flags: err_clr=1 clears both flags at the edge. A set event in the same cycle wins over the clear.
- Reset mid-operation: asserting rst_n=0 in any state discards the posted entry, returns to CLEAR and re-zeroes the whole RAM.
- Single-port RAM model: one write per cycle, asynchronous read.

Test Plan:
- DEPTH_LOG2=4. Release reset -> mem_ready rises exactly 16 cycles later; during those 16 cycles addr_b_read=0. In READY, reading all 16 words returns 0.
- Write: addr_b=0x8, start=4'b1111, write=0xDEADBEEF. Next cycle read 0x8 -> 0xDEADBEEF (forwarded). Two cycles later, with no new writes, still 0xDEADBEEF (from RAM).
- Byte lanes: word 0x4 preloaded 0x11223344. Store start=4'b0001 data 0x000000AA -> reads 0x112233AA. Then start=4'b1000 data 0xBB000000 -> reads 0xBB2233AA.
- Back-to-back: stores to 0x0=0x1 and then 0x4=0x2 on consecutive cycles, reading 0x0 in the second cycle -> returns 0x1. Both words hold their values afterwards.
- Loader: ld_valid=1 with ld_addr=0xC, ld_data=0xCAFEF00D while a store is active -> ld_ready=0. After the posted entry drains, ld_ready=1 and the word is written; read 0xC -> 0xCAFEF00D.
- Errors: store to 0x100 (out of range) -> err_oob=1, no RAM change, read returns 0. Store during CLEAR -> err_busy=1. err_clr=1 -> both flags 0 next cycle. rst_n pulse mid-run -> all words read 0 after the re-clear.
